// File: rtl/mem_copy_dma_pkg.sv
// Shared constants and FSM encoding for the memory copy engine.
// Holds default widths, memory depth and the copy state enum.
package mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Single-port data memory bus.
// master: copy engine (drives enables/addr/wdata); slave: memory.
interface mem_copy_dma_if #(
  parameter int AW = mem_pkg::DEF_ADDR_W,
  parameter int DW = mem_pkg::DEF_DATA_W
);

  logic          MemReadEn;
  logic          MemWriteEn;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic [DW-1:0] MemReadData;

  modport master (
    output MemReadEn,
    output MemWriteEn,
    output MemAddress,
    output MemWriteData,
    input  MemReadData
  );

  modport slave (
    input  MemReadEn,
    input  MemWriteEn,
    input  MemAddress,
    input  MemWriteData,
    output MemReadData
  );

endinterface

// File: rtl/mem_copy_dma_ctrl.sv
// Copy FSM and byte counter: clk/rst, start/length in;
// state, load/accept/step strobes and busy/done out.
module mem_copy_ctrl
  import mem_pkg::*;
#(
  parameter int LEN_W = DEF_ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output state_e           state,
  output logic             accept,
  output logic             load,
  output logic             step,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] count_q;

  assign state  = state_q;
  assign accept = (state_q == IDLE) && start;
  assign load   = accept && (length != '0);
  assign step   = (state_q == WR);
  assign busy   = (state_q == RD) || (state_q == WR);
  assign done   = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        count_q <= length;
      else if (step)
        count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (length != '0) ? RD : DONE;
      end
      RD:   state_d = WR;
      WR: begin
        if (count_q == LEN_W'(1))
          state_d = DONE;
        else
          state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Memory-to-memory byte copy engine (read/write alternating).
// Ports: clk, rst, Start/SrcAddr/DstAddr/Length, Busy, Done, mem bus.
// MEM_COPY_CHECKSUM_EN adds Checksum: mod-2^DATA_W sum of bytes written.
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
  output logic              Busy,
  output logic              Done,
  mem_copy_dma_if.master    mem
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  state_e            state;
  logic              accept;
  logic              load;
  logic              step;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;

  mem_copy_ctrl #(
    .LEN_W(LEN_W)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (Start),
    .length(Length),
    .state (state),
    .accept(accept),
    .load  (load),
    .step  (step),
    .busy  (Busy),
    .done  (Done)
  );

  // Pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
    end else if (load) begin
      src_q <= SrcAddr;
      dst_q <= DstAddr;
    end else if (step) begin
      src_q <= src_q + 1'b1;
      dst_q <= dst_q + 1'b1;
    end
  end

  // Read data is the memory's registered output from the RD edge.
  always_comb begin
    mem.MemReadEn    = 1'b0;
    mem.MemWriteEn   = 1'b0;
    mem.MemAddress   = '0;
    mem.MemWriteData = '0;
    unique case (1'b1)
      (state == RD): begin
        mem.MemReadEn  = 1'b1;
        mem.MemAddress = src_q;
      end
      (state == WR): begin
        mem.MemWriteEn   = 1'b1;
        mem.MemAddress   = dst_q;
        mem.MemWriteData = mem.MemReadData;
      end
      default: ;
    endcase
  end

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      Checksum <= '0;
    else if (accept)
      Checksum <= '0;
    else if (step)
      Checksum <= Checksum + mem.MemWriteData;
  end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural memory.
// Covers single/multi copy, zero length, wrap/overlap, ignored Start, reset.
module tb_mem_copy_dma;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  SrcAddr;
  logic [9:0]  DstAddr;
  logic [10:0] Length;
  logic        Busy;
  logic        Done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0]  Checksum;
`endif

  int n_chk = 0;
  int n_fail = 0;

  mem_copy_dma_if bus ();

  mem_copy_dma dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .SrcAddr(SrcAddr),
    .DstAddr(DstAddr),
    .Length (Length),
    .Busy   (Busy),
    .Done   (Done),
    .mem    (bus)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .Checksum(Checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];

  always @(posedge clk) begin
    if (bus.MemWriteEn)
      ram[bus.MemAddress] <= bus.MemWriteData;
    if (bus.MemReadEn)
      bus.MemReadData <= ram[bus.MemAddress];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, Busy}, 0);
    chk({tag, "_done"}, {31'd0, Done}, 0);
    chk({tag, "_rd"}, {31'd0, bus.MemReadEn}, 0);
    chk({tag, "_wr"}, {31'd0, bus.MemWriteEn}, 0);
    chk({tag, "_addr"}, {22'd0, bus.MemAddress}, 0);
    chk({tag, "_wd"}, {24'd0, bus.MemWriteData}, 0);
  endtask

  // Issues Start then observes 2*len+4 cycles. When poke>0, Start is
  // re-pulsed with other operands at cycle poke and on the Done cycle.
  task automatic run_copy(input int src, input int dst, input int len,
                          input int poke, output int busy_n,
                          output int done_at, output int done_n,
                          output int both_n, output int acc_n);
    busy_n = 0; done_at = 0; done_n = 0; both_n = 0; acc_n = 0;
    SrcAddr = 10'(src);
    DstAddr = 10'(dst);
    Length  = 11'(len);
    Start   = 1'b1;
    tick();
    Start = 1'b0;
    for (int cyc = 1; cyc <= 2 * len + 4; cyc++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at == 0) done_at = cyc;
      end
      if (bus.MemReadEn && bus.MemWriteEn) both_n++;
      if (bus.MemReadEn || bus.MemWriteEn) acc_n++;
      Start = 1'b0;
      if (poke != 0 && (cyc == poke || Done)) begin
        Start   = 1'b1;
        SrcAddr = 10'd5;
        DstAddr = 10'd400;
        Length  = 11'd1;
      end
      tick();
    end
    Start = 1'b0;
  endtask

  int busy_n, done_at, done_n, both_n, acc_n;

  initial begin
    rst = 1'b1;
    Start = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Length = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'hEE;
    tick();
    tick();
    chk_idle_outs("reset");
`ifdef MEM_COPY_CHECKSUM_EN
    chk("reset_csum", {24'd0, Checksum}, 0);
`endif
    rst = 1'b0;
    tick();
    chk_idle_outs("idle");

    // Single byte copy, cycle by cycle
    ram[5] = 8'd97;
    ram[9] = 8'd0;
    SrcAddr = 10'd5; DstAddr = 10'd9; Length = 11'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t1_c1_rd", {31'd0, bus.MemReadEn}, 1);
    chk("t1_c1_wr", {31'd0, bus.MemWriteEn}, 0);
    chk("t1_c1_addr", {22'd0, bus.MemAddress}, 5);
    chk("t1_c1_busy", {31'd0, Busy}, 1);
    tick();
    chk("t1_c2_wr", {31'd0, bus.MemWriteEn}, 1);
    chk("t1_c2_rd", {31'd0, bus.MemReadEn}, 0);
    chk("t1_c2_addr", {22'd0, bus.MemAddress}, 9);
    chk("t1_c2_wd", {24'd0, bus.MemWriteData}, 97);
    tick();
    chk("t1_c3_done", {31'd0, Done}, 1);
    chk("t1_c3_busy", {31'd0, Busy}, 0);
    tick();
    chk("t1_c4_done", {31'd0, Done}, 0);
    chk("t1_mem9", {24'd0, ram[9]}, 97);

    // Four byte copy
    for (int i = 0; i < 4; i++) ram[100 + i] = 8'(i + 1);
    run_copy(100, 200, 4, 0, busy_n, done_at, done_n, both_n, acc_n);
    chk("t2_busy_cycles", busy_n, 8);
    chk("t2_done_at", done_at, 9);
    chk("t2_done_n", done_n, 1);
    chk("t2_both_en", both_n, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_mem%0d", 200 + i), {24'd0, ram[200 + i]}, i + 1);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t2_csum", {24'd0, Checksum}, 10);
`endif

    // Zero length
    ram[8] = 8'd55;
    run_copy(7, 8, 0, 0, busy_n, done_at, done_n, both_n, acc_n);
    chk("t3_done_at", done_at, 1);
    chk("t3_access", acc_n, 0);
    chk("t3_busy", busy_n, 0);
    chk("t3_mem8", {24'd0, ram[8]}, 55);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t3_csum", {24'd0, Checksum}, 0);
`endif

    // Address wrap with overlapping destination
    ram[1022] = 8'd10; ram[1023] = 8'd11;
    ram[0] = 8'd12; ram[1] = 8'd13;
    ram[2] = 8'hEE; ram[3] = 8'hEE;
    run_copy(1022, 0, 4, 0, busy_n, done_at, done_n, both_n, acc_n);
    chk("t4_done_at", done_at, 9);
    chk("t4_mem0", {24'd0, ram[0]}, 10);
    chk("t4_mem1", {24'd0, ram[1]}, 11);
    chk("t4_mem2", {24'd0, ram[2]}, 10);
    chk("t4_mem3", {24'd0, ram[3]}, 11);
    chk("t4_mem1022", {24'd0, ram[1022]}, 10);

    // Start re-pulsed while busy and while in DONE is ignored
    ram[100] = 8'd1; ram[101] = 8'd2;
    ram[300] = 8'hEE; ram[301] = 8'hEE; ram[400] = 8'hEE;
    run_copy(100, 300, 2, 2, busy_n, done_at, done_n, both_n, acc_n);
    chk("t5_done_n", done_n, 1);
    chk("t5_done_at", done_at, 5);
    chk("t5_access", acc_n, 4);
    chk("t5_mem300", {24'd0, ram[300]}, 1);
    chk("t5_mem301", {24'd0, ram[301]}, 2);
    chk("t5_mem400", {24'd0, ram[400]}, 32'hEE);
    tick();
    chk("t5_idle_busy", {31'd0, Busy}, 0);

    // Reset during the third RD of an eight byte copy
    for (int i = 0; i < 8; i++) begin
      ram[100 + i] = 8'(i + 1);
      ram[500 + i] = 8'hEE;
    end
    SrcAddr = 10'd100; DstAddr = 10'd500; Length = 11'd8;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_c5_rd", {31'd0, bus.MemReadEn}, 1);
    chk("t6_c5_addr", {22'd0, bus.MemAddress}, 102);
    rst = 1'b1;
    #1;
    chk_idle_outs("t6_rst");
    tick();
    tick();
    chk("t6_rst_done", {31'd0, Done}, 0);
    rst = 1'b0;
    tick();
    chk("t6_after_done", {31'd0, Done}, 0);
    chk("t6_mem500", {24'd0, ram[500]}, 1);
    chk("t6_mem501", {24'd0, ram[501]}, 2);
    chk("t6_mem502", {24'd0, ram[502]}, 32'hEE);
    chk("t6_mem507", {24'd0, ram[507]}, 32'hEE);
    run_copy(104, 600, 2, 0, busy_n, done_at, done_n, both_n, acc_n);
    chk("t6_re_done_at", done_at, 5);
    chk("t6_mem600", {24'd0, ram[600]}, 5);
    chk("t6_mem601", {24'd0, ram[601]}, 6);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t6_csum", {24'd0, Checksum}, 11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
